// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, then shifts a start/data/parity/stop
// frame out on device clock falls and checks the device acknowledge.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err_tick
);

  localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                      : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] InhLast = CntW'(INHIBIT_CYCLES - 1);
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StRts, StReq, StSend, StWaitIdle} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [3:0]            bit_q, bit_d;
  logic [9:0]            frame_q, frame_d;
  logic                  dbit_q, dbit_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [1:0]            c_sync_q, d_sync_q;
  logic [FILTER_LEN-1:0] c_filt_q, d_filt_q;
  logic                  c_lvl_q, c_lvl_d, d_lvl_q, d_lvl_d;
  logic                  fall;

  // Idle bus is high, so the conditioning chain resets to all ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_sync_q <= '1;
      d_sync_q <= '1;
      c_filt_q <= '1;
      d_filt_q <= '1;
      c_lvl_q  <= 1'b1;
      d_lvl_q  <= 1'b1;
    end else begin
      c_sync_q <= {c_sync_q[0], ps2c_in};
      d_sync_q <= {d_sync_q[0], ps2d_in};
      c_filt_q <= {c_filt_q[FILTER_LEN-2:0], c_sync_q[1]};
      d_filt_q <= {d_filt_q[FILTER_LEN-2:0], d_sync_q[1]};
      c_lvl_q  <= c_lvl_d;
      d_lvl_q  <= d_lvl_d;
    end
  end

  always_comb begin
    c_lvl_d = c_lvl_q;
    d_lvl_d = d_lvl_q;
    if (&c_filt_q)       c_lvl_d = 1'b1;
    else if (~|c_filt_q) c_lvl_d = 1'b0;
    if (&d_filt_q)       d_lvl_d = 1'b1;
    else if (~|d_filt_q) d_lvl_d = 1'b0;
  end

  assign fall = c_lvl_q & ~c_lvl_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      dbit_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      dbit_q  <= dbit_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    dbit_d  = dbit_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A wr coinciding with the terminating tick belongs to the finished transfer.
        if (wr && !done_q && !err_q) begin
          frame_d = {1'b1, ~^din, din};
          bit_d   = '0;
          cnt_d   = '0;
          state_d = StRts;
        end
      end
      StRts: begin
        if (cnt_q == InhLast) begin
          cnt_d   = '0;
          state_d = StReq;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StReq: begin
        dbit_d  = 1'b1;
        cnt_d   = '0;
        state_d = StSend;
      end
      StSend: begin
        if (fall) begin
          cnt_d = '0;
          if (bit_q == 4'd10) begin
            if (!d_lvl_q) begin
              state_d = StWaitIdle;
            end else begin
              err_d   = 1'b1;
              state_d = StIdle;
            end
          end else begin
            dbit_d = ~frame_q[bit_q];
            bit_d  = bit_q + 4'd1;
          end
        end else if (cnt_q == TmoLast) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitIdle: begin
        if (c_lvl_q && d_lvl_q) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else if (fall) begin
          cnt_d = '0;
        end else if (cnt_q == TmoLast) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign ps2c_oe      = (state_q == StRts) || (state_q == StReq);
  assign ps2d_oe      = (state_q == StReq) || ((state_q == StSend) && dbit_q);
  assign tx_idle      = (state_q == StIdle);
  assign tx_done_tick = done_q;
  assign tx_err_tick  = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain device model clocks frames out of the host while a
// scoreboard holds the expected data-line bits and the expected terminating tick.
module tb_ps2_host_tx;

  localparam int INH  = 40;
  localparam int FL   = 4;
  localparam int TMO  = 300;
  localparam int HALF = 30;

  logic       clk = 1'b0;
  logic       reset, wr;
  logic [7:0] din;
  logic       dev_c, dev_d;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err_tick;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int err_cyc = 0;

  bit         exp_bits[$];
  logic [1:0] exp_out[$];   // {done, err}

  assign ps2c_in = ~ps2c_oe & dev_c;
  assign ps2d_in = ~ps2d_oe & dev_d;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (wr),
    .din         (din),
    .ps2c_in     (ps2c_in),
    .ps2d_in     (ps2d_in),
    .ps2c_oe     (ps2c_oe),
    .ps2d_oe     (ps2d_oe),
    .tx_idle     (tx_idle),
    .tx_done_tick(tx_done_tick),
    .tx_err_tick (tx_err_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Terminating ticks are popped against the outcome queue.
  always @(negedge clk) begin
    logic [1:0] eo;
    if (!reset && (tx_done_tick || tx_err_tick)) begin
      err_cyc = cyc;
      n_cmp++;
      if (exp_out.size() == 0) begin
        n_bad++;
        $display("FAIL outcome: got done=%b err=%b, required no tick", tx_done_tick, tx_err_tick);
      end else begin
        eo = exp_out.pop_front();
        if ({tx_done_tick, tx_err_tick} !== eo) begin
          n_bad++;
          $display("FAIL outcome: got done/err=%b, required %b", {tx_done_tick, tx_err_tick}, eo);
        end
      end
      n_cmp++;
      if ({ps2c_oe, ps2d_oe, tx_idle} !== 3'b001) begin
        n_bad++;
        $display("FAIL tick_lines: got c_oe/d_oe/idle=%b, required 001",
                 {ps2c_oe, ps2d_oe, tx_idle});
      end
    end
  end

  function automatic void push_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) begin
      exp_bits.push_back(~b[i]);
      if (b[i]) ones++;
    end
    exp_bits.push_back((ones % 2) == 1);  // oe asserted when the parity bit is 0
    exp_bits.push_back(1'b0);             // stop bit released
  endfunction

  task automatic start_wr(input logic [7:0] b, input logic [1:0] outcome);
    @(negedge clk);
    din = b;
    wr  = 1'b1;
    push_frame(b);
    exp_out.push_back(outcome);
    @(negedge clk);
    wr  = 1'b0;
    din = 8'h00;
  endtask

  task automatic check_rts();
    int  n = 0;
    int  dh = 0;
    bit  lastd = 1'b0;
    n_cmp++;
    if (tx_idle !== 1'b0 || ps2c_oe !== 1'b1) begin
      n_bad++;
      $display("FAIL rts_start: got idle=%b c_oe=%b, required idle=0 c_oe=1", tx_idle, ps2c_oe);
    end
    while (ps2c_oe === 1'b1 && n < 10000) begin
      n++;
      if (ps2d_oe === 1'b1) dh++;
      lastd = ps2d_oe;
      @(negedge clk);
    end
    n_cmp++;
    if (n != INH + 1) begin
      n_bad++;
      $display("FAIL rts_len: got %0d cycles, required %0d", n, INH + 1);
    end
    n_cmp++;
    if (dh != 1 || lastd != 1'b1) begin
      n_bad++;
      $display("FAIL req_cycle: got %0d d_oe cycles last=%b, required 1 last=1", dh, lastd);
    end
  endtask

  task automatic device(input bit ack, input int nfall, input bit glitch);
    int w = 0;
    bit eb;
    while (!(ps2c_oe === 1'b0 && ps2d_oe === 1'b1) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (w >= 1000) begin
      n_bad++;
      $display("FAIL start_bit: got c_oe=%b d_oe=%b, required 0 1", ps2c_oe, ps2d_oe);
    end
    for (int k = 1; k <= nfall; k++) begin
      if (k == 11 && ack) dev_d = 1'b0;
      if (glitch && (k == 3 || k == 7)) begin
        repeat (10) @(negedge clk);
        dev_c = 1'b0;
        repeat (3) @(negedge clk);
        dev_c = 1'b1;
        repeat (HALF - 13) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      dev_c    = 1'b0;
      fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      if (k <= 10) begin
        n_cmp++;
        if (exp_bits.size() == 0) begin
          n_bad++;
          $display("FAIL bit%0d: got d_oe=%b, required nothing queued", k - 1, ps2d_oe);
        end else begin
          eb = exp_bits.pop_front();
          if (ps2d_oe !== eb) begin
            n_bad++;
            $display("FAIL bit%0d: got d_oe=%b, required %b", k - 1, ps2d_oe, eb);
          end
        end
      end
      dev_c = 1'b1;
    end
    dev_d = 1'b1;
  endtask

  task automatic wait_outcome();
    int w = 0;
    while (exp_out.size() != 0 && w < TMO + 1000) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (exp_out.size() != 0) begin
      n_bad++;
      $display("FAIL outcome_wait: got %0d pending ticks, required 0", exp_out.size());
      exp_out.delete();
    end
    exp_bits.delete();
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({ps2c_oe, ps2d_oe, tx_idle} !== 3'b001) begin
      n_bad++;
      $display("FAIL post_idle: got c_oe/d_oe/idle=%b, required 001", {ps2c_oe, ps2d_oe, tx_idle});
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err_tick} !== 5'b00100) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b, required 00100",
               {ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err_tick});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (FL + 4) @(negedge clk);
    n_cmp++;
    if ({ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err_tick} !== 5'b00100) begin
      n_bad++;
      $display("FAIL idle_outputs: got %b, required 00100",
               {ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err_tick});
    end
  endtask

  task automatic test_send(input logic [7:0] b, input bit glitch);
    start_wr(b, 2'b10);
    check_rts();
    device(1'b1, 11, glitch);
    wait_outcome();
  endtask

  task automatic test_nack();
    start_wr(8'h3C, 2'b01);
    check_rts();
    device(1'b0, 11, 1'b0);
    wait_outcome();
  endtask

  task automatic test_timeout();
    start_wr(8'hED, 2'b01);
    check_rts();
    device(1'b1, 4, 1'b0);
    wait_outcome();
    n_cmp++;
    if (err_cyc - fall_cyc != 3 + FL + TMO) begin
      n_bad++;
      $display("FAIL timeout_len: got %0d cycles pin-fall to err, required %0d",
               err_cyc - fall_cyc, 3 + FL + TMO);
    end
  endtask

  task automatic test_wr_ignored();
    start_wr(8'hED, 2'b10);
    check_rts();
    fork
      device(1'b1, 11, 1'b0);
      begin
        repeat (100) @(negedge clk);
        din = 8'h55;
        wr  = 1'b1;
        @(negedge clk);
        wr  = 1'b0;
      end
    join
    wait_outcome();
  endtask

  task automatic reset_pulse(input string name);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({ps2c_oe, ps2d_oe, tx_idle} !== 3'b001) begin
      n_bad++;
      $display("FAIL %s: got c_oe/d_oe/idle=%b, required 001", name, {ps2c_oe, ps2d_oe, tx_idle});
    end
    exp_bits.delete();
    exp_out.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (FL + 4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    start_wr(8'hA5, 2'b10);
    repeat (10) @(negedge clk);
    reset_pulse("reset_in_rts");
    start_wr(8'hA5, 2'b10);
    check_rts();
    repeat (5) @(negedge clk);
    reset_pulse("reset_in_send");
    test_send(8'hF4, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    wr    = 1'b0;
    din   = 8'h00;
    dev_c = 1'b1;
    dev_d = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_send(8'hED, 1'b0);
    test_send(8'h01, 1'b0);
    test_send(8'hFF, 1'b1);
    test_nack();
    test_timeout();
    test_wr_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
